// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D main-memory arbiter.
package mem_arb_pkg;

    localparam int RD_LAT = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_OWN_I = 2'b01,
        ARB_OWN_D = 2'b10
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Read-owner tag pipeline: {valid, owner} delayed by DEPTH cycles.
module mem_arb_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_vld,
    input  logic push_own,
    output logic pop_vld,
    output logic pop_own
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] own;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            own <= '0;
        end else begin
            vld[0] <= push_vld;
            own[0] <= push_own;
            for (int k = 1; k < DEPTH; k++) begin
                vld[k] <= vld[k-1];
                own[k] <= own[k-1];
            end
        end
    end

    assign pop_vld = vld[DEPTH-1];
    assign pop_own = own[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Burst arbiter sharing main memory between I-cache and D-cache fills.
// Optional MEM_ARB_PERF_EN adds grant and wait counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = mem_arb_pkg::RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data_in,
    input  logic [3:0]        m_busy,
    input  logic [DATA_W-1:0] m_data_out,
    input  logic              m_err,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data_in,
    output logic              m_rd,
    output logic              m_wr,
    output logic              i_gnt,
    output logic              d_gnt,
    output logic              i_acc,
    output logic              d_acc,
    output logic              i_valid,
    output logic              d_valid,
    output logic [DATA_W-1:0] i_data_out,
    output logic [DATA_W-1:0] d_data_out,
    output logic              i_err,
`ifdef MEM_ARB_PERF_EN
    output logic [15:0]       i_grant_cnt,
    output logic [15:0]       d_grant_cnt,
    output logic [15:0]       wait_cnt,
`endif
    output logic              d_err
);

    arb_state_t state;
    arb_state_t state_nx;
    owner_t     last_owner;
    logic       d_bad;
    logic       acc;
    logic       pop_vld;
    logic       pop_own;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_owner <= OWN_I;
        end else begin
            state <= state_nx;
            if (state == ARB_OWN_I && !i_req)
                last_owner <= OWN_I;
            else if (state == ARB_OWN_D && !d_req)
                last_owner <= OWN_D;
        end
    end

    // Owners always pass through IDLE, so arbitration only happens there.
    always_comb begin
        state_nx = state;
        unique case (state)
            ARB_IDLE: begin
                if (i_req && d_req)
                    state_nx = (last_owner == OWN_I) ? ARB_OWN_D : ARB_OWN_I;
                else if (i_req)
                    state_nx = ARB_OWN_I;
                else if (d_req)
                    state_nx = ARB_OWN_D;
            end
            ARB_OWN_I: if (!i_req) state_nx = ARB_IDLE;
            ARB_OWN_D: if (!d_req) state_nx = ARB_IDLE;
            default:   state_nx = ARB_IDLE;
        endcase
    end

    assign i_gnt = (state == ARB_OWN_I);
    assign d_gnt = (state == ARB_OWN_D);
    assign d_bad = d_gnt & d_rd & d_wr;

    always_comb begin
        m_addr    = '0;
        m_data_in = '0;
        m_rd      = 1'b0;
        m_wr      = 1'b0;
        unique case (1'b1)
            i_gnt: begin
                m_addr = i_addr;
                m_rd   = i_rd;
            end
            d_gnt: begin
                m_addr    = d_addr;
                m_data_in = d_data_in;
                m_rd      = d_rd & ~d_bad;
                m_wr      = d_wr & ~d_bad;
            end
            default: ;
        endcase
    end

    assign acc   = (m_rd | m_wr) & ~m_busy[m_addr[2:1]];
    assign i_acc = i_gnt & acc;
    assign d_acc = d_gnt & acc;

    mem_arb_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (acc & m_rd),
        .push_own (d_gnt),
        .pop_vld  (pop_vld),
        .pop_own  (pop_own)
    );

    // Return routing follows the tag, not the current grant.
    assign i_valid    = pop_vld & (pop_own == OWN_I);
    assign d_valid    = pop_vld & (pop_own == OWN_D);
    assign i_data_out = i_valid ? m_data_out : '0;
    assign d_data_out = d_valid ? m_data_out : '0;

    assign i_err = i_gnt & m_err;
    assign d_err = d_gnt & (m_err | d_bad);

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
            wait_cnt    <= '0;
        end else begin
            if (state == ARB_IDLE && state_nx == ARB_OWN_I)
                i_grant_cnt <= sat_inc(i_grant_cnt);
            if (state == ARB_IDLE && state_nx == ARB_OWN_D)
                d_grant_cnt <= sat_inc(d_grant_cnt);
            if ((i_req && !i_gnt) || (d_req && !d_gnt))
                wait_cnt <= sat_inc(wait_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic vs a model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_rd, d_req, d_rd, d_wr, m_err;
    logic [15:0] i_addr, d_addr, d_data_in, m_data_out;
    logic [3:0]  m_busy;
    logic [15:0] m_addr, m_data_in, i_data_out, d_data_out;
    logic        m_rd, m_wr, i_gnt, d_gnt, i_acc, d_acc;
    logic        i_valid, d_valid, i_err, d_err;

    int n_chk = 0;
    int n_err = 0;

    // model: owner 0=none 1=I 2=D, last owner, cycle count, return queue
    int own_s, last_s, cyc;
    int due_q[$];
    int side_q[$];
    logic seen_i_acc, seen_d_acc;

    mem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_rd       (i_rd),
        .i_addr     (i_addr),
        .d_req      (d_req),
        .d_rd       (d_rd),
        .d_wr       (d_wr),
        .d_addr     (d_addr),
        .d_data_in  (d_data_in),
        .m_busy     (m_busy),
        .m_data_out (m_data_out),
        .m_err      (m_err),
        .m_addr     (m_addr),
        .m_data_in  (m_data_in),
        .m_rd       (m_rd),
        .m_wr       (m_wr),
        .i_gnt      (i_gnt),
        .d_gnt      (d_gnt),
        .i_acc      (i_acc),
        .d_acc      (d_acc),
        .i_valid    (i_valid),
        .d_valid    (d_valid),
        .i_data_out (i_data_out),
        .d_data_out (d_data_out),
        .i_err      (i_err),
        .d_err      (d_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [9:0] dut_flags();
        return {i_gnt, d_gnt, i_acc, d_acc, m_rd, m_wr,
                i_valid, d_valid, i_err, d_err};
    endfunction

    task automatic clr();
        i_req = 0; i_rd = 0; i_addr = 0;
        d_req = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_data_in = 0;
        m_busy = 0; m_err = 0; m_data_out = 0;
    endtask

    // One cycle: compare outputs to the model, then advance both.
    task automatic step();
        logic ig, dg, bad, erd, ewr, busy, eacc;
        logic [15:0] eaddr, edin;
        logic [9:0] ef;
        int side;
        m_data_out = 16'($urandom);
        #1;
        ig    = (own_s == 1);
        dg    = (own_s == 2);
        bad   = dg && d_rd && d_wr;
        eaddr = ig ? i_addr : (dg ? d_addr : 16'h0);
        edin  = dg ? d_data_in : 16'h0;
        erd   = (ig && i_rd) || (dg && d_rd && !bad);
        ewr   = dg && d_wr && !bad;
        busy  = m_busy[(eaddr / 2) % 4];
        eacc  = (erd || ewr) && !busy;
        side  = 0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            side = side_q[0];
            void'(due_q.pop_front());
            void'(side_q.pop_front());
        end
        ef = {ig, dg, ig && eacc, dg && eacc, erd, ewr,
              side == 1, side == 2, ig && m_err, dg && (m_err || bad)};
        check("flags", {22'd0, dut_flags()}, {22'd0, ef});
        check("m_addr", {16'd0, m_addr}, {16'd0, eaddr});
        check("m_data_in", {16'd0, m_data_in}, {16'd0, edin});
        check("i_data", {16'd0, i_data_out},
              {16'd0, (side == 1) ? m_data_out : 16'h0});
        check("d_data", {16'd0, d_data_out},
              {16'd0, (side == 2) ? m_data_out : 16'h0});
        seen_i_acc = i_acc;
        seen_d_acc = d_acc;
        if (eacc && erd) begin
            due_q.push_back(cyc + 2);
            side_q.push_back(own_s);
        end
        @(posedge clk);
        cyc++;
        if (own_s == 0) begin
            if (i_req && d_req) own_s = (last_s == 1) ? 2 : 1;
            else if (i_req)     own_s = 1;
            else if (d_req)     own_s = 2;
        end else if (own_s == 1 && !i_req) begin
            own_s = 0; last_s = 1;
        end else if (own_s == 2 && !d_req) begin
            own_s = 0; last_s = 2;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        check("rst_flags", {22'd0, dut_flags()}, 32'd0);
        check("rst_m_addr", {16'd0, m_addr}, 32'd0);
        check("rst_m_data_in", {16'd0, m_data_in}, 32'd0);
        own_s = 0; last_s = 1;
        due_q.delete(); side_q.delete();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst_n = 1;
    endtask

    task automatic issue_i(input logic [15:0] a);
        i_rd = 1; i_addr = a;
        seen_i_acc = 0;
        for (int k = 0; k < 8 && !seen_i_acc; k++) step();
        check("i_acc_timeout", {31'd0, seen_i_acc}, 32'd1);
        i_rd = 0;
    endtask

    task automatic issue_d(input logic [15:0] a, input logic rd,
                           input logic wr, input logic [15:0] dat);
        d_rd = rd; d_wr = wr; d_addr = a; d_data_in = dat;
        seen_d_acc = 0;
        for (int k = 0; k < 8 && !seen_d_acc; k++) step();
        check("d_acc_timeout", {31'd0, seen_d_acc}, 32'd1);
        d_rd = 0; d_wr = 0;
    endtask

    initial begin
        rst_n = 1; cyc = 0; own_s = 0; last_s = 1;
        clr();
        @(posedge clk);
        #1;
        do_reset();

        // I burst alone
        i_req = 1;
        step();
        issue_i(16'h1230);
        issue_i(16'h1232);
        issue_i(16'h1234);
        issue_i(16'h1236);
        i_req = 0;
        repeat (4) step();

        // tie after reset: D first, one IDLE cycle, then I
        do_reset();
        i_req = 1; d_req = 1;
        repeat (3) step();
        d_req = 0;
        repeat (3) step();
        i_req = 0;
        repeat (2) step();

        // bank conflict on bank 1
        d_req = 1;
        repeat (2) step();
        m_busy = 4'b0010;
        d_wr = 1; d_addr = 16'h0402; d_data_in = 16'hBEEF;
        repeat (3) step();
        check("conflict_no_acc", {31'd0, seen_d_acc}, 32'd0);
        m_busy = 4'b0000;
        step();
        check("conflict_acc", {31'd0, seen_d_acc}, 32'd1);
        d_wr = 0;

        // handover with a D read in flight
        issue_d(16'h0010, 1'b1, 1'b0, 16'h0);
        d_req = 0; i_req = 1;
        repeat (5) step();
        i_req = 0;
        repeat (2) step();

        // illegal d_rd & d_wr
        d_req = 1;
        repeat (2) step();
        d_rd = 1; d_wr = 1;
        step();
        d_rd = 0; d_wr = 0; d_req = 0;
        repeat (3) step();

        // reset one cycle after an accepted I read
        i_req = 1;
        step();
        issue_i(16'h0100);
        i_req = 0;
        do_reset();
        repeat (4) step();

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 7) == 0) i_req = ~i_req;
            if ($urandom_range(0, 7) == 0) d_req = ~d_req;
            i_rd      = ($urandom_range(0, 1) == 0);
            d_rd      = ($urandom_range(0, 2) == 0);
            d_wr      = ($urandom_range(0, 2) == 0);
            i_addr    = 16'($urandom);
            d_addr    = 16'($urandom);
            d_data_in = 16'($urandom);
            m_busy    = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            m_err     = ($urandom_range(0, 15) == 0);
            if (n == 1000) do_reset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
